fir_transposed_param: RTL and testbench

Parametrised N-tap transposed-form FIR filter for the DSP chain. It has runtime-loadable coefficients behind a shadow/active double bank. It adds round-to-nearest and saturation on the output, plus a sample-gated accumulator chain, so it tolerates gaps in the input stream. It is the general replacement for the fixed 4-tap transposed FIR and sits between the sample source and downstream decimation/gain stages.

---
 rtl/fir_transposed_param.sv | 161 ++++++++++++++++
 tb/tb_fir_transposed_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_transposed_param.sv
// Parametrised transposed-form FIR with shadow/active coefficient banks,
// sample-gated accumulator chain, round-half-up and output saturation.
module fir_transposed_param #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_TAPS    = 8,
  parameter int FRAC_BITS   = 15,
  parameter int ADDR_W      = $clog2(NUM_TAPS),
  parameter int ACC_W       = DATA_WIDTH + COEFF_WIDTH + $clog2(NUM_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  data_in,
  input  logic                          valid_in,
  input  logic                          flush,
  input  logic                          coeff_wr_en,
  input  logic        [ADDR_W-1:0]      coeff_wr_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_wr_data,
  input  logic                          coeff_commit,
  output logic signed [DATA_WIDTH-1:0]  data_out,
  output logic                          valid_out,
  output logic                          sat_out
);

  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;

  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] ROUND_HALF =
    {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS-1);

  function automatic logic signed [ACC_W-1:0] mul_ext(
    input logic signed [DATA_WIDTH-1:0]  x,
    input logic signed [COEFF_WIDTH-1:0] c
  );
    logic signed [PROD_W-1:0] p;
    p = x * c;
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Headroom in ACC_W guarantees the rounding add cannot wrap.
  function automatic logic signed [ACC_W-1:0] round_half_up(
    input logic signed [ACC_W-1:0] y
  );
    logic signed [ACC_W-1:0] s;
    s = y + ROUND_HALF;
    return s >>> FRAC_BITS;
  endfunction

  function automatic logic is_clamped(input logic signed [ACC_W-1:0] y);
    return (y > SAT_MAX) || (y < SAT_MIN);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] clamp(
    input logic signed [ACC_W-1:0] y
  );
    logic signed [DATA_WIDTH-1:0] r;
    if (y > SAT_MAX) begin
      r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (y < SAT_MIN) begin
      r = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      r = y[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  logic signed [COEFF_WIDTH-1:0] shadow_r [NUM_TAPS];
  logic signed [COEFF_WIDTH-1:0] active_r [NUM_TAPS];
  logic signed [ACC_W-1:0]       acc_r    [1:NUM_TAPS-1];
  logic signed [ACC_W-1:0]       hist_s   [1:NUM_TAPS-1];
  logic signed [ACC_W-1:0]       prod_s   [NUM_TAPS];
  logic signed [ACC_W-1:0]       y_full_s;
  logic signed [ACC_W-1:0]       y_rnd_s;
  logic signed [DATA_WIDTH-1:0]  y_sat_s;
  logic                          sat_s;
  logic                          addr_ok_s;

  assign addr_ok_s = ({1'b0, coeff_wr_addr} < (ADDR_W+1)'(NUM_TAPS));

  // Per-tap products against the active bank, and flush-masked chain history.
  always_comb begin
    for (int k = 0; k < NUM_TAPS; k++) begin
      prod_s[k] = mul_ext(data_in, active_r[k]);
    end
    for (int k = 1; k < NUM_TAPS; k++) begin
      if (flush) begin
        hist_s[k] = {ACC_W{1'b0}};
      end else begin
        hist_s[k] = acc_r[k];
      end
    end
  end

  // Output path: full-precision sum, rounding and clamping.
  always_comb begin
    y_full_s = prod_s[0] + hist_s[1];
    y_rnd_s  = round_half_up(y_full_s);
    y_sat_s  = clamp(y_rnd_s);
    sat_s    = is_clamped(y_rnd_s);
  end

  // Coefficient banks; a write in the commit cycle is forwarded into the active bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_r[k] <= {COEFF_WIDTH{1'b0}};
        active_r[k] <= {COEFF_WIDTH{1'b0}};
      end
    end else begin
      if (coeff_wr_en && addr_ok_s) begin
        shadow_r[coeff_wr_addr] <= coeff_wr_data;
      end
      if (coeff_commit) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          if (coeff_wr_en && addr_ok_s && (coeff_wr_addr == ADDR_W'(k))) begin
            active_r[k] <= coeff_wr_data;
          end else begin
            active_r[k] <= shadow_r[k];
          end
        end
      end
    end
  end

  // Transposed accumulator chain, advanced only on accepted samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k < NUM_TAPS; k++) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end
    end else if (valid_in) begin
      for (int k = 1; k < NUM_TAPS-1; k++) begin
        acc_r[k] <= prod_s[k] + hist_s[k+1];
      end
      acc_r[NUM_TAPS-1] <= prod_s[NUM_TAPS-1];
    end else if (flush) begin
      for (int k = 1; k < NUM_TAPS; k++) begin
        acc_r[k] <= {ACC_W{1'b0}};
      end
    end
  end

  // Registered outputs; data and saturation flag hold between samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= {DATA_WIDTH{1'b0}};
      sat_out   <= 1'b0;
      valid_out <= 1'b0;
    end else if (valid_in) begin
      data_out  <= y_sat_s;
      sat_out   <= sat_s;
      valid_out <= 1'b1;
    end else begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_transposed_param.sv
// Self-checking bench for fir_transposed_param (NUM_TAPS=4, Q1.15): directed
// table/sequence checks plus randomized traffic against a per-sample model.
module tb_fir_transposed_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_in;
  logic        valid_in;
  logic        flush;
  logic        coeff_wr_en;
  logic [1:0]  coeff_wr_addr;
  logic [15:0] coeff_wr_data;
  logic        coeff_commit;
  logic [15:0] data_out;
  logic        valid_out;
  logic        sat_out;

  int total = 0;
  int bad   = 0;

  fir_transposed_param #(
    .DATA_WIDTH(16), .COEFF_WIDTH(16), .NUM_TAPS(4), .FRAC_BITS(15)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in), .flush(flush),
    .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr),
    .coeff_wr_data(coeff_wr_data), .coeff_commit(coeff_commit),
    .data_out(data_out), .valid_out(valid_out), .sat_out(sat_out)
  );

  always #5 clk = ~clk;

  // Model: each accepted sample remembers the coefficient set active when it
  // arrived; y[n] = sum over history j of c_at(n-j)[j] * x[n-j].
  int          m_shadow [4];
  int          m_active [4];
  int          m_hx     [4];
  int          m_hc     [4][4];
  logic [15:0] e_data;
  logic        e_valid;
  logic        e_sat;

  typedef struct {
    logic [15:0] x;
    logic [15:0] exp_d;
  } vec_t;
  vec_t tbl [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear_hist();
    for (int j = 0; j < 4; j++) begin
      m_hx[j] = 0;
      for (int k = 0; k < 4; k++) m_hc[j][k] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear_hist();
    for (int k = 0; k < 4; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    e_data = 16'h0000; e_valid = 1'b0; e_sat = 1'b0;
  endtask

  task automatic model_step();
    longint y;
    longint yr;
    if (flush) model_clear_hist();
    if (valid_in) begin
      for (int j = 3; j > 0; j--) begin
        m_hx[j] = m_hx[j-1];
        m_hc[j] = m_hc[j-1];
      end
      m_hx[0] = int'($signed(data_in));
      m_hc[0] = m_active;
      y = 64'sd0;
      for (int j = 0; j < 4; j++) y += longint'(m_hc[j][j]) * longint'(m_hx[j]);
      yr = (y + 64'sd16384) >>> 15;
      if (yr > 64'sd32767) begin
        e_data = 16'h7FFF; e_sat = 1'b1;
      end else if (yr < -64'sd32768) begin
        e_data = 16'h8000; e_sat = 1'b1;
      end else begin
        e_data = yr[15:0]; e_sat = 1'b0;
      end
      e_valid = 1'b1;
    end else begin
      e_valid = 1'b0;
    end
    if (coeff_wr_en) m_shadow[coeff_wr_addr] = int'($signed(coeff_wr_data));
    if (coeff_commit) m_active = m_shadow;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; data_in = 16'h0000; flush = 1'b0;
    coeff_wr_en = 1'b0; coeff_wr_addr = 2'd0; coeff_wr_data = 16'h0000; coeff_commit = 1'b0;
  endtask

  // One clock: drive, step model, then compare all outputs #1 after the edge.
  task automatic cyc(input logic v, input logic [15:0] x, input logic f, input logic w,
                     input logic [1:0] a, input logic [15:0] d, input logic cm);
    valid_in = v; data_in = x; flush = f;
    coeff_wr_en = w; coeff_wr_addr = a; coeff_wr_data = d; coeff_commit = cm;
    model_step();
    @(posedge clk);
    #1;
    chk("valid_out", {31'd0, valid_out}, {31'd0, e_valid});
    chk("data_out", {16'd0, data_out}, {16'd0, e_data});
    chk("sat_out", {31'd0, sat_out}, {31'd0, e_sat});
    idle_inputs();
  endtask

  task automatic smp(input logic [15:0] x);
    cyc(1'b1, x, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0);
  endtask

  task automatic do_flush();
    cyc(1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0);
  endtask

  task automatic load(input logic [15:0] c0, input logic [15:0] c1,
                      input logic [15:0] c2, input logic [15:0] c3);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 2'd0, c0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 2'd1, c1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 2'd2, c2, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b1, 2'd3, c3, 1'b1);
  endtask

  task automatic impulse_table(input string tag);
    for (int i = 0; i < 5; i++) begin
      smp(tbl[i].x);
      chk({tag, "_d"}, {16'd0, data_out}, {16'd0, tbl[i].exp_d});
      chk({tag, "_s"}, {31'd0, sat_out}, 32'd0);
    end
  endtask

  initial begin
    tbl[0] = '{16'h4000, 16'h1000};
    tbl[1] = '{16'h0000, 16'h2000};
    tbl[2] = '{16'h0000, 16'h2000};
    tbl[3] = '{16'h0000, 16'h1000};
    tbl[4] = '{16'h0000, 16'h0000};

    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_data", {16'd0, data_out}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_sat", {31'd0, sat_out}, 32'd0);
    rst = 1'b0;

    // Zero banks after reset: a sample yields zero output.
    smp(16'h7FFF);
    chk("zero_bank", {16'd0, data_out}, 32'd0);

    // Impulse response, back-to-back.
    load(16'h2000, 16'h4000, 16'h4000, 16'h2000);
    impulse_table("impulse");

    // Gapped impulse: identical outputs, held data while idle.
    do_flush();
    for (int i = 0; i < 5; i++) begin
      smp(tbl[i].x);
      chk("gap_d", {16'd0, data_out}, {16'd0, tbl[i].exp_d});
      for (int g = 0; g < 3; g++) begin
        idle();
        chk("gap_vld", {31'd0, valid_out}, 32'd0);
        chk("gap_hold", {16'd0, data_out}, {16'd0, tbl[i].exp_d});
      end
    end

    // Saturation, positive then negative full scale.
    load(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    do_flush();
    smp(16'h7FFF);
    chk("satp0_d", {16'd0, data_out}, 32'h7FFE);
    chk("satp0_s", {31'd0, sat_out}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      smp(16'h7FFF);
      chk("satp_d", {16'd0, data_out}, 32'h7FFF);
      chk("satp_s", {31'd0, sat_out}, 32'd1);
    end
    do_flush();
    smp(16'h8000);
    chk("satn0_d", {16'd0, data_out}, 32'h8001);
    chk("satn0_s", {31'd0, sat_out}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      smp(16'h8000);
      chk("satn_d", {16'd0, data_out}, 32'h8000);
      chk("satn_s", {31'd0, sat_out}, 32'd1);
    end

    // Commit in the same cycle as the second sample.
    load(16'h2000, 16'h4000, 16'h4000, 16'h2000);
    do_flush();
    smp(16'h4000);
    chk("cm0", {16'd0, data_out}, 32'h1000);
    cyc(1'b1, 16'h4000, 1'b0, 1'b1, 2'd0, 16'h7FFF, 1'b1);
    chk("cm1_old_c0", {16'd0, data_out}, 32'h3000);
    smp(16'h2000);
    chk("cm2_new_c0", {16'd0, data_out}, 32'h6000);

    // Flush together with a sample.
    load(16'h2000, 16'h4000, 16'h4000, 16'h2000);
    smp(16'h1234); smp(16'h4000); smp(16'h0100);
    cyc(1'b1, 16'h4000, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0);
    chk("flush_v", {16'd0, data_out}, 32'h1000);
    for (int i = 1; i < 5; i++) begin
      smp(16'h0000);
      chk("flush_tail", {16'd0, data_out}, {16'd0, tbl[i].exp_d});
    end

    // Asynchronous reset between samples 2 and 3.
    do_flush();
    smp(16'h4000);
    smp(16'h0000);
    valid_in = 1'b1; data_in = 16'h0000;
    rst = 1'b1;
    #2;
    chk("arst_data", {16'd0, data_out}, 32'd0);
    chk("arst_valid", {31'd0, valid_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("arst_drop", {31'd0, valid_out}, 32'd0);
    chk("arst_sat", {31'd0, sat_out}, 32'd0);
    rst = 1'b0;
    model_reset();
    idle_inputs();
    load(16'h2000, 16'h4000, 16'h4000, 16'h2000);
    impulse_table("post_rst");

    // Randomized traffic against the model.
    load(16'($urandom), 16'($urandom), 16'($urandom_range(0, 16'h3FFF)), 16'($urandom));
    for (int i = 0; i < 400; i++) begin
      logic [15:0] x;
      case ($urandom_range(0, 5))
        0: x = 16'h7FFF;
        1: x = 16'h8000;
        default: x = 16'($urandom);
      endcase
      cyc(1'($urandom_range(0, 9) < 7), x, 1'($urandom_range(0, 29) == 0),
          1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
          ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 16'h0FFF)) : 16'($urandom),
          1'($urandom_range(0, 14) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
